wb_dcache: RTL and testbench
============================

WB_DCACHE -- requirements
Module: wb_dcache

Interface
REQ-001 Parameter ADDR_W, 16, word-address width.
REQ-002 Parameter DATA_W, 16, data word width.
REQ-003 Parameter SETS, 8, number of lines; power of 2, 2 or more.
REQ-004 Parameter LINE_WORDS, 4, words per line; power of 2, 2 or more.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 addr  in  ADDR_W  CPU word address.
REQ-008 wdata  in  DATA_W  CPU store data.
REQ-009 re / we  in  1 each  CPU read / write request; we has priority if both are high.
REQ-010 rdata  out  DATA_W  read data; valid when rdy=1 and re=1.
REQ-011 rdy  out  1  access complete this cycle; 0 stalls the pipeline.
REQ-012 flush  in  1  level request to write back all dirty lines.
REQ-013 flush_done  out  1  one-cycle pulse when the flush completes.
REQ-014 mem_req  out  1  memory word-transfer request.
REQ-015 mem_we  out  1  1 = write beat, 0 = read beat.
REQ-016 mem_addr  out  ADDR_W  memory word address.
REQ-017 mem_wdata  out  DATA_W  write-beat data.
REQ-018 mem_rdata  in  DATA_W  read-beat data; valid with mem_ack.
REQ-019 mem_ack  in  1  beat accepted/returned; any latency of 1 or more cycles.

Function
REQ-020 Organisation: direct-mapped, write-back, write-allocate; addr = {tag, index[log2 SETS], offset[log2 LINE_WORDS]}.
REQ-021 Hit = valid[index] & tag match, state IDLE, no flush active.
- Read hit: rdata and rdy=1 combinationally, in the same cycle.
- Write hit: rdy=1 the same cycle; word written and dirty set at the next edge.
REQ-022 Idle (re=we=0): rdy=1, no state change.
REQ-023 Miss: rdy=0.
- Victim dirty: go to WB, then FILL.
- Victim clean: go straight to FILL.
- Requester holds addr/re/we/wdata stable until rdy=1.
REQ-024 FSM states: IDLE, WB, FILL, FLUSH.
- IDLE->WB on dirty miss; IDLE->FILL on clean miss.
- WB->FILL after the last beat.
- FILL->IDLE after the last beat; the retried access then hits.
- IDLE->FLUSH on flush=1 with no request pending.
- FLUSH->IDLE after the last set.
REQ-025 Beats issue in order, offset 0 to LINE_WORDS-1; mem_addr = {tag, index, beat}.
- Beat counter advances only on mem_ack and wraps to 0 at LINE_WORDS-1.
- mem_req stays high between beats of one line.
REQ-026 WB beats: mem_we=1, mem_wdata = victim word.
REQ-027 FILL beats: mem_we=0.
- Each acked word is written into the line.
- Last ack writes the new tag, valid=1, dirty=0.
REQ-028 A miss is processed before flush (flush ignored while rdy=0).
- A new re/we during FLUSH is stalled with rdy=0.
REQ-029 FLUSH scan: sets 0..SETS-1.
- Dirty valid set: LINE_WORDS write beats, then dirty cleared; valid kept.
- Clean set: 1 cycle, no beats.
- flush_done pulses in the cycle after the last set completes.
REQ-030 mem_req=0 in IDLE; mem_req never drops mid-beat before mem_ack.

Reset
REQ-031 While rst_n=0, at each edge:
- state=IDLE, all valid=0, all dirty=0, beat and set counters=0.
REQ-032 Combinational outputs with rst_n=0:
- mem_req=0, flush_done=0.
- rdy=1 when re=we=0; rdy=0 on any access, since all lines are invalid.
REQ-033 Reset during WB/FILL/FLUSH aborts the transfer; dirty data is discarded; mem_req=0 from the next cycle.
REQ-034 Data-array contents are not reset.

Structure
REQ-035 Shared package holds:
- state encoding enum;
- field-width functions (offset, index and tag widths from the parameters);
- default parameter constants.
REQ-036 One sub-module, dcache_tag_array: valid/dirty/tag storage, read and write ports.
- Data array is inferred inside wb_dcache.

Verification (SETS=8, LINE_WORDS=4, memory ack latency 3)
REQ-037 Cold read at 0x0010 with mem[0x10..0x13]=A,B,C,D.
- 4 read beats at 0x10..0x13; rdy=1 with rdata=A once the fill completes.
- A following read at 0x0013 returns D with rdy=1 in the same cycle.
REQ-038 Write 0x1234 to 0x0011, then read 0x0011.
- Hit with rdy=1 both times; rdata=0x1234; no memory traffic.
REQ-039 After REQ-038, read 0x0091 (same index, different tag).
- 4 write beats at 0x10..0x13, with beat 1 = 0x1234.
- Then 4 read beats at 0x90..0x93.
REQ-040 Make sets 2 and 5 dirty, then raise flush.
- Exactly 8 write beats (set 2 first), then flush_done pulses once.
- All dirty bits are cleared afterwards.
REQ-041 Drop rst_n after the second fill beat.
- mem_req=0 next cycle; a read of the same address afterwards misses and refetches.
REQ-042 re and we both high on a hit: the write is performed and no read response is required.

Source files
------------

// File: rtl/wb_dcache_pkg.sv
// Shared types and field-width helpers for the write-back data cache.
// Widths derive from the word-address layout {tag, index, offset}.
package wb_dcache_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_SETS       = 8;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_FILL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set valid/dirty/tag storage: one combinational read port, one write port.
// Valid and dirty clear on reset; tags are left untouched.
module dcache_tag_array
    import wb_dcache_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = tag_w(DEF_ADDR_W, DEF_SETS, DEF_LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [idx_w(SETS)-1:0]   rd_idx,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_W-1:0]         rd_tag,
    input  logic                     wr_en,
    input  logic [idx_w(SETS)-1:0]   wr_idx,
    input  logic                     wr_valid,
    input  logic                     wr_dirty,
    input  logic [TAG_W-1:0]         wr_tag
);

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tags [SETS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/wb_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// memory port and a full-cache flush scan.
module wb_dcache
    import wb_dcache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    input  logic              flush,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int OW = off_w(LINE_WORDS);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);
    localparam logic [IW-1:0] LAST_SET  = IW'(SETS - 1);

    state_t          state;
    state_t          state_nx;
    logic [OW-1:0]   beat;
    logic [IW-1:0]   set_cnt;
    logic            done_q;

    logic [OW-1:0]   a_off;
    logic [IW-1:0]   a_idx;
    logic [TW-1:0]   a_tag;
    logic [IW-1:0]   look_idx;
    logic            line_valid;
    logic            line_dirty;
    logic [TW-1:0]   line_tag;
    logic            req;
    logic            hit;
    logic            last_ack;
    logic            flush_line;
    logic            set_done;

    logic            tag_we;
    logic            tag_wdirty;
    logic [TW-1:0]   tag_wtag;

    logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];

    assign a_off    = addr[OW-1:0];
    assign a_idx    = addr[OW+IW-1:OW];
    assign a_tag    = addr[ADDR_W-1:OW+IW];
    // The flush scan walks sets by counter; everything else follows the CPU index.
    assign look_idx = (state == S_FLUSH) ? set_cnt : a_idx;

    dcache_tag_array #(
        .SETS  (SETS),
        .TAG_W (TW)
    ) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (look_idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .wr_en    (tag_we),
        .wr_idx   (look_idx),
        .wr_valid (1'b1),
        .wr_dirty (tag_wdirty),
        .wr_tag   (tag_wtag)
    );

    assign req        = re | we;
    assign hit        = rst_n && (state == S_IDLE) && line_valid && (line_tag == a_tag);
    assign rdy        = !req || hit;
    assign rdata      = data_mem[{a_idx, a_off}];
    assign last_ack   = mem_ack && (beat == LAST_BEAT);
    assign flush_line = line_valid && line_dirty;
    assign set_done   = !flush_line || last_ack;
    assign mem_wdata  = data_mem[{look_idx, beat}];
    assign flush_done = done_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req && !hit) begin
                    state_nx = flush_line ? S_WB : S_FILL;
                end else if (flush && !req && !done_q) begin
                    state_nx = S_FLUSH;
                end
            end
            S_WB:    if (last_ack) state_nx = S_FILL;
            S_FILL:  if (last_ack) state_nx = S_IDLE;
            S_FLUSH: if (set_done && (set_cnt == LAST_SET)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {a_tag, a_idx, beat};
        tag_we     = 1'b0;
        tag_wdirty = 1'b0;
        tag_wtag   = a_tag;
        case (state)
            S_IDLE: begin
                if (we && hit) begin
                    tag_we     = 1'b1;
                    tag_wdirty = 1'b1;
                end
            end
            S_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {line_tag, a_idx, beat};
            end
            S_FILL: begin
                mem_req = 1'b1;
                tag_we  = last_ack;
            end
            S_FLUSH: begin
                mem_req  = flush_line;
                mem_we   = flush_line;
                mem_addr = {line_tag, set_cnt, beat};
                tag_we   = flush_line && last_ack;
                tag_wtag = line_tag;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req = 1'b0;
            tag_we  = 1'b0;
        end
    end

    // Beat and set counters wrap naturally because both sizes are powers of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat    <= '0;
            set_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            if (mem_req && mem_ack) begin
                beat <= beat + 1'b1;
            end
            if ((state == S_FLUSH) && set_done) begin
                set_cnt <= set_cnt + 1'b1;
            end
            done_q <= (state == S_FLUSH) && set_done && (set_cnt == LAST_SET);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (we && hit) begin
                data_mem[{a_idx, a_off}] <= wdata;
            end else if ((state == S_FILL) && mem_ack) begin
                data_mem[{a_idx, beat}] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_dcache.sv
// Randomized bench for wb_dcache: a flat CPU-visible memory plus a tag-level
// cache model predict read data and the exact memory beat sequence.
module tb_wb_dcache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
    logic [15:0] rdata;
    logic        rdy;
    logic        flush;
    logic        flush_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    wb_dcache #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .SETS       (8),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .wdata      (wdata),
        .re         (re),
        .we         (we),
        .rdata      (rdata),
        .rdy        (rdy),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // ram is the backing store; golden is what the CPU must observe.
    logic [15:0] ram    [65536];
    logic [15:0] golden [65536];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [10:0] m_tag   [8];

    logic [32:0] exp_q[$];
    logic [32:0] log_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: three cycles of mem_req before each ack.
    initial begin
        int lat;
        lat       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                lat     = 0;
            end else if (mem_req) begin
                lat++;
                if (lat == 3) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        ram[mem_addr] = mem_wdata;
                        log_q.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = ram[mem_addr];
                        log_q.push_back({1'b0, mem_addr, ram[mem_addr]});
                    end
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic compare_beats(input string tag);
        check_eq({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && log_q.size() > 0) begin
            check_eq(tag, 64'(log_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        log_q.delete();
    endtask

    task automatic do_access(input logic do_re, input logic do_we,
                             input logic [15:0] a, input logic [15:0] d);
        logic [2:0]  idx;
        logic [10:0] tg;
        logic [1:0]  kb;
        logic [15:0] ba;
        logic        exp_hit;
        int          cyc;
        idx     = a[4:2];
        tg      = a[15:5];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 4; k++) begin
                    kb = k[1:0];
                    ba = {m_tag[idx], idx, kb};
                    exp_q.push_back({1'b1, ba, golden[ba]});
                end
            end
            for (int k = 0; k < 4; k++) begin
                kb = k[1:0];
                ba = {tg, idx, kb};
                exp_q.push_back({1'b0, ba, golden[ba]});
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        @(negedge clk);
        addr  = a;
        re    = do_re;
        we    = do_we;
        wdata = d;
        #1;
        check_eq("first_rdy", 64'(rdy), 64'(exp_hit));
        cyc = 0;
        while (!rdy && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("rdy_done", 64'(rdy), 64'd1);
        if (do_re && !do_we) begin
            check_eq("rdata", 64'(rdata), 64'(golden[a]));
        end
        if (do_we) begin
            golden[a]    = d;
            m_dirty[idx] = 1'b1;
        end
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
        compare_beats("beat");
    endtask

    task automatic do_flush();
        logic [2:0]  s3;
        logic [1:0]  kb;
        logic [15:0] ba;
        int          pulses;
        int          cyc;
        for (int s = 0; s < 8; s++) begin
            s3 = s[2:0];
            if (m_valid[s] && m_dirty[s]) begin
                for (int k = 0; k < 4; k++) begin
                    kb = k[1:0];
                    ba = {m_tag[s], s3, kb};
                    exp_q.push_back({1'b1, ba, golden[ba]});
                end
            end
        end
        @(negedge clk);
        flush  = 1'b1;
        pulses = 0;
        cyc    = 0;
        while (pulses == 0 && cyc < 1000) begin
            @(negedge clk);
            #1;
            if (flush_done) pulses++;
            cyc++;
        end
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (flush_done) pulses++;
        end
        check_eq("flush_done_pulses", 64'(pulses), 64'd1);
        compare_beats("flush_beat");
        for (int s = 0; s < 8; s++) m_dirty[s] = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        for (int i = 0; i < 65536; i++) golden[i] = ram[i];
        exp_q.delete();
        log_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          op;
        logic [15:0] ra;
        logic [15:0] rd;

        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        re    = 1'b0;
        we    = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[16'h0010] = 16'hA0A0;
        ram[16'h0011] = 16'hB1B1;
        ram[16'h0012] = 16'hC2C2;
        ram[16'h0013] = 16'hD3D3;
        model_reset();

        // Reset-state outputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_flush_done", 64'(flush_done), 64'd0);
        check_eq("rst_rdy_idle", 64'(rdy), 64'd1);
        re = 1'b1;
        #1;
        check_eq("rst_rdy_access", 64'(rdy), 64'd0);
        re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Cold fill, then hit within the line.
        do_access(1'b1, 1'b0, 16'h0010, 16'h0);
        do_access(1'b1, 1'b0, 16'h0013, 16'h0);
        check_eq("line_word_d", 64'(golden[16'h0013]), 64'hD3D3);
        // Write hit then read hit, no traffic.
        do_access(1'b0, 1'b1, 16'h0011, 16'h1234);
        do_access(1'b1, 1'b0, 16'h0011, 16'h0);
        // Read and write together on a hit: the write wins.
        do_access(1'b1, 1'b1, 16'h0012, 16'h5678);
        do_access(1'b1, 1'b0, 16'h0012, 16'h0);
        // Conflicting tag: dirty victim written back before the fill.
        do_access(1'b1, 1'b0, 16'h0091, 16'h0);
        check_eq("wb_beat1_in_ram", 64'(ram[16'h0011]), 64'h1234);

        // Dirty sets 2 and 5, then flush; a second flush must find nothing dirty.
        do_access(1'b0, 1'b1, 16'h0028, 16'h2222);
        do_access(1'b0, 1'b1, 16'h0054, 16'h5555);
        do_flush();
        check_eq("flush_ram_set2", 64'(ram[16'h0028]), 64'h2222);
        check_eq("flush_ram_set5", 64'(ram[16'h0054]), 64'h5555);
        do_flush();

        // Randomized traffic with periodic flushes.
        for (int n = 0; n < 120; n++) begin
            op = int'($urandom_range(0, 3));
            ra = 16'($urandom_range(0, 511));
            rd = 16'($urandom);
            case (op)
                0, 1: do_access(1'b1, 1'b0, ra, rd);
                2:    do_access(1'b0, 1'b1, ra, rd);
                default: do_access(1'b1, 1'b1, ra, rd);
            endcase
            if (n % 30 == 29) do_flush();
        end

        // Reset in the middle of a fill aborts it; the line is refetched later.
        do_flush();
        @(negedge clk);
        addr = 16'h0E04;
        re   = 1'b1;
        cyc  = 0;
        while (log_q.size() < 2 && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("beats_before_reset", 64'(log_q.size()), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        #1;
        check_eq("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mid_flush_done", 64'(flush_done), 64'd0);
        re = 1'b0;
        #1;
        check_eq("rst_mid_rdy_idle", 64'(rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_access(1'b1, 1'b0, 16'h0E04, 16'h0);
        do_access(1'b1, 1'b0, 16'h0E07, 16'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
